// File: rtl/instr_loader.sv
// Boot-time program loader: byte stream -> 32-bit words -> imem writes.
// Define LOADER_CHECKSUM_EN to add a trailing XOR checksum byte and ERROR state.
module instr_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic        i_start,
  input  logic        i_byte_valid,
  input  logic [7:0]  i_byte_data,
  output logic        o_byte_ready,
  output logic        o_imem_we,
  output logic [31:0] o_imem_addr,
  output logic [31:0] o_imem_wdata,
  output logic        o_core_hold,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_DATA,
    S_WRITE,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;
  localparam state_t S_FIN = S_CHECK;
`else
  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_DATA,
    S_WRITE,
    S_DONE
  } state_t;
  localparam state_t S_FIN = S_DONE;
`endif

  state_t                  r_state;
  state_t                  w_next;
  logic [7:0]              r_left;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [ADDR_WIDTH-1:0]   r_waddr;
  logic [1:0]              r_bcnt;
  logic [23:0]             r_buf;
  logic [31:0]             r_wdata;
  logic [31:0]             w_shift;
  logic                    w_fire;
  logic                    w_idle;
  logic                    w_start;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]              r_csum;
`endif

  assign w_fire  = i_byte_valid & o_byte_ready;
  assign w_shift = {i_byte_data, r_buf};

`ifdef LOADER_CHECKSUM_EN
  assign w_idle = (r_state == S_IDLE) ||
                  (r_state == S_DONE) ||
                  (r_state == S_ERROR);
`else
  assign w_idle = (r_state == S_IDLE) ||
                  (r_state == S_DONE);
`endif
  assign w_start = i_start & w_idle;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (i_start) w_next = S_HEADER;
      end
      S_HEADER: begin
        if (w_fire)
          w_next = (i_byte_data == 8'd0) ? S_FIN : S_DATA;
      end
      S_DATA: begin
        if (w_fire && r_bcnt == 2'd3) w_next = S_WRITE;
      end
      S_WRITE: begin
        w_next = (r_left == 8'd1) ? S_FIN : S_DATA;
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (w_fire)
          w_next = (i_byte_data == r_csum) ? S_DONE : S_ERROR;
      end
      S_ERROR: begin
        if (i_start) w_next = S_HEADER;
      end
`endif
      S_DONE: begin
        if (i_start) w_next = S_HEADER;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
      r_left  <= 8'd0;
      r_addr  <= '0;
      r_waddr <= '0;
      r_bcnt  <= 2'd0;
      r_buf   <= 24'd0;
      r_wdata <= 32'd0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_addr <= '0;
        r_bcnt <= 2'd0;
      end
      if (r_state == S_HEADER && w_fire)
        r_left <= i_byte_data;
      if (r_state == S_DATA && w_fire) begin
        r_bcnt <= r_bcnt + 2'd1;
        r_buf  <= w_shift[31:8];
        // capture the finished word so the write port holds it
        if (r_bcnt == 2'd3) begin
          r_wdata <= w_shift;
          r_waddr <= r_addr;
        end
      end
      if (r_state == S_WRITE) begin
        r_addr <= r_addr + ADDR_WIDTH'(1);
        r_left <= r_left - 8'd1;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_csum <= 8'd0;
    end else if (w_start) begin
      r_csum <= 8'd0;
    end else if (r_state == S_DATA && w_fire) begin
      r_csum <= r_csum ^ i_byte_data;
    end
  end

  assign o_error = (r_state == S_ERROR);
  assign o_byte_ready = (r_state == S_HEADER) ||
                        (r_state == S_DATA) ||
                        (r_state == S_CHECK);
  assign o_busy = (r_state == S_HEADER) ||
                  (r_state == S_DATA) ||
                  (r_state == S_WRITE) ||
                  (r_state == S_CHECK);
`else
  assign o_error = 1'b0;
  assign o_byte_ready = (r_state == S_HEADER) ||
                        (r_state == S_DATA);
  assign o_busy = (r_state == S_HEADER) ||
                  (r_state == S_DATA) ||
                  (r_state == S_WRITE);
`endif

  assign o_imem_we    = (r_state == S_WRITE);
  assign o_imem_addr  = 32'(r_waddr);
  assign o_imem_wdata = r_wdata;
  assign o_done       = (r_state == S_DONE);
  assign o_core_hold  = (r_state != S_DONE);

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: write scoreboard plus literal checks.
// Follows LOADER_CHECKSUM_EN to append checksum bytes when it is defined.
module tb_instr_loader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        bv = 1'b0;
  logic [7:0]  bd = 8'd0;
  logic        ready;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        hold;
  logic        busy;
  logic        done;
  logic        err;

  instr_loader #(.ADDR_WIDTH(8)) dut (
    .i_clock      (clk),
    .i_reset_n    (rst_n),
    .i_start      (start),
    .i_byte_valid (bv),
    .i_byte_data  (bd),
    .o_byte_ready (ready),
    .o_imem_we    (we),
    .o_imem_addr  (addr),
    .o_imem_wdata (wdata),
    .o_core_hold  (hold),
    .o_busy       (busy),
    .o_done       (done),
    .o_error      (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  int          n_total = 0;
  int          n_pass = 0;
  int          n_writes = 0;
  logic [31:0] last_a = 32'd0;
  logic [31:0] last_d = 32'd0;
  logic [31:0] img[$];
  wr_t         exp_q[$];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  // Scoreboard: every write must match the next expected image word.
  always @(negedge clk) begin
    if (rst_n) begin
      check("hold_vs_done", {31'd0, hold}, {31'd0, ~done});
      if (we) begin
        wr_t e;
        n_writes++;
        last_a = addr;
        last_d = wdata;
        check("ready_in_write", {31'd0, ready}, 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_write", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", addr, e.a);
          check("wr_data", wdata, e.d);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bv = 1'b1;
    bd = b;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (ready) begin
        @(posedge clk);
        #1;
        bv = 1'b0;
        return;
      end
    end
    check("byte_timeout", 32'd1, 32'd0);
    bv = 1'b0;
  endtask

  task automatic do_start();
    bv = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_load(input bit toggle);
    logic [7:0] cs;
    logic [7:0] b;
    cs = 8'd0;
    for (int i = 0; i < img.size(); i++)
      exp_q.push_back({32'(i), img[i]});
    send_byte(8'(img.size()));
    for (int i = 0; i < img.size(); i++) begin
      for (int j = 0; j < 4; j++) begin
        b = img[i][8*j +: 8];
        cs = cs ^ b;
        send_byte(b);
        if (toggle) begin
          @(posedge clk);
          #1;
        end
      end
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(cs);
`endif
  endtask

  task automatic wait_end();
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (done || err) return;
    end
    check("end_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_hold", {31'd0, hold}, 32'd1);
    check("rst_ready", {31'd0, ready}, 32'd0);
    rst_n = 1'b1;
    bv = 1'b1;
    bd = 8'h55;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("idle_hold", {31'd0, hold}, 32'd1);
    check("idle_ready", {31'd0, ready}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_done", {31'd0, done}, 32'd0);
    check("idle_err", {31'd0, err}, 32'd0);
    check("idle_addr", addr, 32'd0);
    check("idle_wdata", wdata, 32'd0);
    check("idle_nwr", 32'(n_writes), 32'd0);

    // single word
    do_start();
    img = '{32'h12345678};
    run_load(1'b0);
    wait_end();
    check("w1_done", {31'd0, done}, 32'd1);
    check("w1_hold", {31'd0, hold}, 32'd0);
    check("w1_err", {31'd0, err}, 32'd0);
    check("w1_busy", {31'd0, busy}, 32'd0);
    check("w1_nwr", 32'(n_writes), 32'd1);
    check("w1_last_a", last_a, 32'd0);
    check("w1_last_d", last_d, 32'h12345678);
    check("w1_hold_d", wdata, 32'h12345678);

    // byte_valid while DONE must not be consumed
    bv = 1'b1;
    bd = 8'h03;
    repeat (5) begin
      @(negedge clk);
      check("done_ready", {31'd0, ready}, 32'd0);
    end
    check("done_stays", {31'd0, done}, 32'd1);

    // restart from DONE, extra start while busy, three words toggling
    do_start();
    @(negedge clk);
    check("rs_hold", {31'd0, hold}, 32'd1);
    check("rs_done", {31'd0, done}, 32'd0);
    check("rs_busy", {31'd0, busy}, 32'd1);
    check("rs_ready", {31'd0, ready}, 32'd1);
    do_start();
    img = '{32'hE3A00001, 32'hE2800001, 32'hEAFFFFFE};
    run_load(1'b1);
    wait_end();
    check("w3_done", {31'd0, done}, 32'd1);
    check("w3_nwr", 32'(n_writes), 32'd4);
    check("w3_last_a", last_a, 32'd2);
    check("w3_addr", addr, 32'd2);
    check("w3_wdata", wdata, 32'hEAFFFFFE);

    // empty image
    do_start();
    img.delete();
    run_load(1'b0);
    wait_end();
    check("n0_done", {31'd0, done}, 32'd1);
    check("n0_hold", {31'd0, hold}, 32'd0);
    check("n0_nwr", 32'(n_writes), 32'd4);

    // reset after two data bytes discards the partial word
    do_start();
    send_byte(8'd1);
    send_byte(8'hAA);
    send_byte(8'hBB);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("ab_busy", {31'd0, busy}, 32'd0);
    check("ab_hold", {31'd0, hold}, 32'd1);
    check("ab_ready", {31'd0, ready}, 32'd0);
    check("ab_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_start();
    img = '{32'hCAFEF00D};
    run_load(1'b0);
    wait_end();
    check("ab_fin_done", {31'd0, done}, 32'd1);
    check("ab_nwr", 32'(n_writes), 32'd5);
    check("ab_last_a", last_a, 32'd0);
    check("ab_last_d", last_d, 32'hCAFEF00D);

`ifdef LOADER_CHECKSUM_EN
    // bad checksum
    do_start();
    exp_q.push_back({32'd0, 32'h12345678});
    send_byte(8'h01);
    send_byte(8'h78);
    send_byte(8'h56);
    send_byte(8'h34);
    send_byte(8'h12);
    send_byte(8'h09);
    wait_end();
    check("ck_err", {31'd0, err}, 32'd1);
    check("ck_done", {31'd0, done}, 32'd0);
    check("ck_hold", {31'd0, hold}, 32'd1);
    check("ck_ready", {31'd0, ready}, 32'd0);
    check("ck_nwr", 32'(n_writes), 32'd6);
    do_start();
    @(negedge clk);
    check("ck_clr_err", {31'd0, err}, 32'd0);
    check("ck_clr_busy", {31'd0, busy}, 32'd1);
    send_byte(8'h00);
    send_byte(8'h00);
    wait_end();
    check("ck_n0_done", {31'd0, done}, 32'd1);
`endif

    repeat (3) @(posedge clk);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end
endmodule
